// File: rtl/parking_lot_controller_pkg.sv
// Shared definitions for the parking lot gate/slot controller.
// Holds the gate sequencer state encoding used by the top level.
package parking_lot_controller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADMIT = 2'd1,
        EXIT  = 2'd2,
        GATE  = 2'd3
    } gate_state_t;

endpackage

// File: rtl/parking_lot_controller_slot_allocator.sv
// Combinational lowest-index free slot finder over the occupancy vector.
// any_free is low when every slot is occupied; free_idx is then 0.
module parking_lot_controller_slot_allocator
    import parking_lot_controller_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = 3
) (
    input  logic [NUM_SLOTS-1:0] slot_status,
    output logic [SLOT_W-1:0]    free_idx,
    output logic                 any_free
);

    // Scanning downward lets the lowest free index overwrite any higher one.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_status[i]) begin
                free_idx = SLOT_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_lot_controller.sv
// N-slot car park gate controller: admits cars into the lowest free slot,
// releases slots on exit, sequences the gate door and tracks parked minutes.
module parking_lot_controller
    import parking_lot_controller_pkg::*;
#(
    parameter int NUM_SLOTS   = 8,
    parameter int SLOT_W      = 3,
    parameter int DOOR_CYCLES = 16,
    parameter int TIME_W      = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_min,
    input  logic                 entry_req,
    input  logic                 exit_req,
    input  logic [SLOT_W-1:0]    exit_slot,
    input  logic                 car_present,
    output logic                 door_open,
    output logic                 full,
    output logic [SLOT_W:0]      available,
    output logic [NUM_SLOTS-1:0] slot_status,
    output logic [SLOT_W-1:0]    assigned_slot,
    output logic                 assign_valid,
    output logic                 entry_rej,
    output logic                 exit_done,
    output logic                 exit_err,
    output logic [TIME_W-1:0]    exit_duration
);

    localparam int              DOOR_W    = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);
    localparam logic [SLOT_W:0] AVAIL_MAX = (SLOT_W + 1)'(NUM_SLOTS);
    localparam logic [SLOT_W:0] AVAIL_ONE = (SLOT_W + 1)'(1);

    gate_state_t       state;
    logic              entry_d;
    logic              exit_d;
    logic              ent_p;
    logic              ext_p;
    logic [SLOT_W-1:0] ext_slot;
    logic [DOOR_W-1:0] door_cnt;
    logic [TIME_W-1:0] timer [NUM_SLOTS];
    logic [SLOT_W-1:0] free_idx;
    logic              any_free;
    logic              exit_in_range;
    logic              admit_ok;
    logic              exit_ok;
    logic [SLOT_W:0]   avail_next;

    parking_lot_controller_slot_allocator #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_alloc (
        .slot_status (slot_status),
        .free_idx    (free_idx),
        .any_free    (any_free)
    );

    // Decisions taken in the one-cycle ADMIT/EXIT states, shared by the FSM and timers.
    always_comb begin
        exit_in_range = ({1'b0, ext_slot} < AVAIL_MAX);
        admit_ok      = (state == ADMIT) && !full && car_present && any_free;
        exit_ok       = (state == EXIT) && exit_in_range && slot_status[ext_slot];
        avail_next    = available;
        if (admit_ok) begin
            avail_next = available - AVAIL_ONE;
        end else if (exit_ok) begin
            avail_next = available + AVAIL_ONE;
        end
    end

    // One-deep pending flags; a rise arriving while its flag is already set is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_d  <= 1'b0;
            exit_d   <= 1'b0;
            ent_p    <= 1'b0;
            ext_p    <= 1'b0;
            ext_slot <= '0;
        end else begin
            entry_d <= entry_req;
            exit_d  <= exit_req;
            if (state == ADMIT) begin
                ent_p <= 1'b0;
            end else if (entry_req && !entry_d) begin
                ent_p <= 1'b1;
            end
            if (state == EXIT) begin
                ext_p <= 1'b0;
            end else if (exit_req && !exit_d && !ext_p) begin
                ext_p    <= 1'b1;
                ext_slot <= exit_slot;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            door_open     <= 1'b0;
            door_cnt      <= '0;
            full          <= 1'b0;
            available     <= AVAIL_MAX;
            slot_status   <= '0;
            assigned_slot <= '0;
            assign_valid  <= 1'b0;
            entry_rej     <= 1'b0;
            exit_done     <= 1'b0;
            exit_err      <= 1'b0;
            exit_duration <= '0;
        end else begin
            assign_valid <= 1'b0;
            entry_rej    <= 1'b0;
            exit_done    <= 1'b0;
            exit_err     <= 1'b0;
            available    <= avail_next;
            full         <= (avail_next == '0);
            case (state)
                IDLE: begin
                    if (ext_p) begin
                        state <= EXIT;
                    end else if (ent_p) begin
                        state <= ADMIT;
                    end
                end
                ADMIT: begin
                    if (admit_ok) begin
                        slot_status[free_idx] <= 1'b1;
                        assigned_slot         <= free_idx;
                        assign_valid          <= 1'b1;
                        door_open             <= 1'b1;
                        door_cnt              <= '0;
                        state                 <= GATE;
                    end else begin
                        entry_rej <= 1'b1;
                        state     <= IDLE;
                    end
                end
                EXIT: begin
                    if (exit_ok) begin
                        slot_status[ext_slot] <= 1'b0;
                        exit_duration         <= timer[ext_slot];
                        exit_done             <= 1'b1;
                        door_open             <= 1'b1;
                        door_cnt              <= '0;
                        state                 <= GATE;
                    end else begin
                        exit_err <= 1'b1;
                        state    <= IDLE;
                    end
                end
                GATE: begin
                    if (door_cnt == DOOR_LAST) begin
                        door_open <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        door_cnt <= door_cnt + DOOR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Allocation or release zeroes a timer; the release reads the pre-increment value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if ((admit_ok && (free_idx == SLOT_W'(i))) ||
                    (exit_ok && (ext_slot == SLOT_W'(i)))) begin
                    timer[i] <= '0;
                end else if (tick_min && slot_status[i] && (timer[i] != '1)) begin
                    timer[i] <= timer[i] + TIME_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_parking_lot_controller.sv
// Self-checking bench for parking_lot_controller (4 slots, 4-cycle door, 4-bit timers).
// A small occupancy/timer model pushes expected pulses to a scoreboard popped by a monitor.
module tb_parking_lot_controller;

    localparam int NS = 4;
    localparam int SW = 2;
    localparam int DC = 4;
    localparam int TW = 4;

    localparam logic [1:0] K_ASSIGN = 2'd0;
    localparam logic [1:0] K_REJ    = 2'd1;
    localparam logic [1:0] K_DONE   = 2'd2;
    localparam logic [1:0] K_ERR    = 2'd3;

    typedef struct packed {
        logic [1:0]    kind;
        logic [SW-1:0] slot;
        logic [TW-1:0] dur;
    } sb_item_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick_min;
    logic          entry_req;
    logic          exit_req;
    logic [SW-1:0] exit_slot;
    logic          car_present;
    logic          door_open;
    logic          full;
    logic [SW:0]   available;
    logic [NS-1:0] slot_status;
    logic [SW-1:0] assigned_slot;
    logic          assign_valid;
    logic          entry_rej;
    logic          exit_done;
    logic          exit_err;
    logic [TW-1:0] exit_duration;

    sb_item_t      sb_q[$];
    sb_item_t      mon_exp;
    logic [1:0]    mon_kind;
    logic [NS-1:0] m_status;
    logic [TW-1:0] m_timer [NS];
    int            checks   = 0;
    int            failures = 0;
    int            door_count;
    logic          door_seen;

    parking_lot_controller #(
        .NUM_SLOTS   (NS),
        .SLOT_W      (SW),
        .DOOR_CYCLES (DC),
        .TIME_W      (TW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tick_min      (tick_min),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .exit_slot     (exit_slot),
        .car_present   (car_present),
        .door_open     (door_open),
        .full          (full),
        .available     (available),
        .slot_status   (slot_status),
        .assigned_slot (assigned_slot),
        .assign_valid  (assign_valid),
        .entry_rej     (entry_rej),
        .exit_done     (exit_done),
        .exit_err      (exit_err),
        .exit_duration (exit_duration)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
        end
    endtask

    task automatic watchDoor(input int n);
        door_seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            door_seen = door_seen | door_open;
            step();
        end
    endtask

    // Model serves the exit before the entry, matching the gate's priority.
    task automatic applyStimulus(input bit do_entry, input bit car, input bit do_exit,
                                 input logic [SW-1:0] slot);
        sb_item_t it;
        if (do_exit) begin
            it.kind = K_ERR;
            it.slot = slot;
            it.dur  = '0;
            if (m_status[slot]) begin
                it.kind        = K_DONE;
                it.dur         = m_timer[slot];
                m_status[slot] = 1'b0;
                m_timer[slot]  = '0;
            end
            sb_q.push_back(it);
        end
        if (do_entry) begin
            it.kind = K_REJ;
            it.slot = '0;
            it.dur  = '0;
            if (m_status != '1 && car) begin
                it.kind = K_ASSIGN;
                for (int i = NS - 1; i >= 0; i--) begin
                    if (!m_status[i]) it.slot = SW'(i);
                end
                m_status[it.slot] = 1'b1;
                m_timer[it.slot]  = '0;
            end
            sb_q.push_back(it);
        end
        car_present = car;
        entry_req   = do_entry;
        exit_req    = do_exit;
        exit_slot   = slot;
        step();
        entry_req = 1'b0;
        exit_req  = 1'b0;
    endtask

    task automatic tickMinutes(input int n);
        for (int k = 0; k < n; k++) begin
            tick_min = 1'b1;
            for (int j = 0; j < NS; j++) begin
                if (m_status[j] && m_timer[j] != '1) m_timer[j] = m_timer[j] + TW'(1);
            end
            step();
            tick_min = 1'b0;
            step();
        end
    endtask

    // Every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && (assign_valid || entry_rej || exit_done || exit_err)) begin
            checkOutput("pulse_onehot", 32'($countones({assign_valid, entry_rej, exit_done, exit_err})), 32'd1);
            mon_kind = exit_err ? K_ERR : exit_done ? K_DONE : entry_rej ? K_REJ : K_ASSIGN;
            if (sb_q.size() == 0) begin
                checkOutput("sb_unexpected_pulse", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_exp = sb_q.pop_front();
                checkOutput("sb_kind", 32'(mon_kind), 32'(mon_exp.kind));
                if (mon_exp.kind == K_ASSIGN) begin
                    checkOutput("sb_assigned_slot", 32'(assigned_slot), 32'(mon_exp.slot));
                    checkOutput("sb_slot_set", 32'(slot_status[mon_exp.slot]), 32'd1);
                end
                if (mon_exp.kind == K_DONE) begin
                    checkOutput("sb_exit_duration", 32'(exit_duration), 32'(mon_exp.dur));
                    checkOutput("sb_slot_clear", 32'(slot_status[mon_exp.slot]), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        tick_min    = 1'b0;
        entry_req   = 1'b0;
        exit_req    = 1'b0;
        exit_slot   = '0;
        car_present = 1'b0;
        m_status    = '0;
        for (int i = 0; i < NS; i++) m_timer[i] = '0;
        waitCycles(3);
        checkOutput("rst_door", 32'(door_open), 32'd0);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_available", 32'(available), 32'(NS));
        checkOutput("rst_status", 32'(slot_status), 32'd0);
        checkOutput("rst_assigned", 32'(assigned_slot), 32'd0);
        checkOutput("rst_duration", 32'(exit_duration), 32'd0);
        checkOutput("rst_pulses", 32'({assign_valid, entry_rej, exit_done, exit_err}), 32'd0);
        reset = 1'b0;
        step();

        $display("[TB] first admit latency and door length");
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        checkOutput("lat_t1", 32'(assign_valid), 32'd0);
        step();
        checkOutput("lat_t2", 32'(assign_valid), 32'd0);
        step();
        checkOutput("lat_t3", 32'(assign_valid), 32'd1);
        checkOutput("lat_door", 32'(door_open), 32'd1);
        checkOutput("adm1_status", 32'(slot_status), 32'b0001);
        checkOutput("adm1_available", 32'(available), 32'd3);
        door_count = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            door_count += int'(door_open);
        end
        checkOutput("door_cycles", 32'(door_count), 32'(DC));
        waitCycles(3);

        $display("[TB] fill the lot, then a refused entry");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, '0);
            waitCycles(10);
        end
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_available", 32'(available), 32'd0);
        checkOutput("fill_status", 32'(slot_status), 32'hF);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        watchDoor(10);
        checkOutput("rej_full_door", 32'(door_seen), 32'd0);
        checkOutput("rej_full_avail", 32'(available), 32'd0);

        $display("[TB] timed exit from slot 1 and reuse");
        tickMinutes(5);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd1);
        waitCycles(10);
        checkOutput("exit1_duration", 32'(exit_duration), 32'd5);
        checkOutput("exit1_status", 32'(slot_status), 32'b1101);
        checkOutput("exit1_available", 32'(available), 32'd1);
        checkOutput("exit1_full", 32'(full), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        waitCycles(10);
        checkOutput("reuse_slot", 32'(assigned_slot), 32'd1);
        checkOutput("reuse_status", 32'(slot_status), 32'hF);

        $display("[TB] exit from a free slot and entry without a car");
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd2);
        waitCycles(10);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd2);
        watchDoor(10);
        checkOutput("err_door", 32'(door_seen), 32'd0);
        checkOutput("err_status", 32'(slot_status), 32'b1011);
        checkOutput("err_available", 32'(available), 32'd1);
        checkOutput("err_duration_held", 32'(exit_duration), 32'd5);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        watchDoor(10);
        checkOutput("nocar_door", 32'(door_seen), 32'd0);
        checkOutput("nocar_status", 32'(slot_status), 32'b1011);

        $display("[TB] simultaneous exit and entry, then timer saturation");
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd0);
        waitCycles(20);
        checkOutput("simul_slot", 32'(assigned_slot), 32'd0);
        checkOutput("simul_status", 32'(slot_status), 32'b1011);
        tickMinutes(20);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0);
        waitCycles(10);
        checkOutput("sat_duration", 32'(exit_duration), 32'd15);
        checkOutput("sat_status", 32'(slot_status), 32'b1010);

        $display("[TB] reset during the gate sequence");
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        waitCycles(2);
        checkOutput("gate_open", 32'(door_open), 32'd1);
        step();
        entry_req = 1'b1;
        exit_req  = 1'b1;
        exit_slot = 2'd1;
        waitCycles(2);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_door", 32'(door_open), 32'd0);
        checkOutput("mid_rst_available", 32'(available), 32'(NS));
        checkOutput("mid_rst_status", 32'(slot_status), 32'd0);
        checkOutput("mid_rst_full", 32'(full), 32'd0);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        m_status  = '0;
        for (int i = 0; i < NS; i++) m_timer[i] = '0;
        step();
        reset = 1'b0;
        watchDoor(15);
        checkOutput("post_rst_door", 32'(door_seen), 32'd0);
        checkOutput("post_rst_available", 32'(available), 32'(NS));

        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
